obuf_a_arb: RTL and testbench
=============================

# obuf_a_arb

Output-port arbiter and two-entry output buffer for one direction of a mesh node. It sits directly downstream of the five per-input-port IBUF_A_CTRL instances. It takes their per-direction `arb_req` bits and registered payloads, returns a one-hot `arb_gnt` plus a shared `obuf_rdy`, and drives the outgoing link with a valid/ready handshake. One instance is built per output direction (N, W, S, E, local B).

## Interface
Parameters:
- `PYLD_W`, 23, payload width in bits; must match the input buffer controllers.
- `NSRC`, 5, number of requesting input ports; fixed at 5, with index 0..4 = N, W, S, E, B.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `req_i`  in  5  bit i = input port i's `arb_req` bit for this output direction.
- `pyld_i`  in  5*PYLD_W  input port i's `payload_o` occupies bits [i*PYLD_W +: PYLD_W].
- `arb_gnt`  out  5  one-hot or zero; registered grant, fed back to input port i as its `arb_gnt` bit.
- `obuf_rdy`  out  1  registered; high when the buffer can accept a push this cycle. Broadcast to all input ports.
- `out_vld`  out  1  head entry valid toward the downstream link.
- `out_pyld`  out  PYLD_W  head entry payload.
- `out_src`  out  3  head entry source port index, 0..4.
- `out_rdy`  in  1  downstream accepts the head entry when `out_vld & out_rdy`.

## Operation
- Transfer (push) happens when `|(arb_gnt & req_i) & obuf_rdy`. The granted port's payload and its index are written into the FIFO.
- The input controller clears its request on the edge after the transfer. The arbiter never assumes the request is still present after a transfer.
- Arbiter FSM:
  - IDLE: `arb_gnt == 0`. If `req_i != 0`, select a winner and load `arb_gnt` with its one-hot code on the next edge, then go to GRANT.
  - GRANT: the grant is held, unchanged, until one of two things happens.
    - The transfer completes. The pointer advances to winner+1 (mod 5). If `req_i & ~arb_gnt` is non-zero, the next winner is selected from that mask and loaded directly, staying in GRANT. This gives back-to-back 1 transfer/cycle. Otherwise, go to IDLE.
    - The granted `req_i` bit drops without a transfer (protocol recovery). `arb_gnt` goes to 0 on the next edge, the FSM goes to IDLE, and the pointer is unchanged.
- Winner selection: round-robin search from the pointer, i.e. the first set bit at index ptr, ptr+1, … mod 5. The pointer is 3 bits, range 0..4, and wraps 4→0.
- FIFO: 2 entries, each holding `{src[2:0], pyld}`. Write/read pointers are 1 bit each; `count` is 2 bits (0..2).
  - Push and pop in the same cycle are both allowed; count is unchanged and the data order is preserved.
  - Push is only accepted when `obuf_rdy` is high. A pop from an empty FIFO is impossible because `out_vld` is 0.
- `obuf_rdy` next = (`count_next != 2`). It is conservative: it ignores a pop in the same cycle.
- `out_vld` = (count != 0). `out_pyld` and `out_src` come from the read entry. These three are driven combinationally from registers, with no path from `out_rdy`.
- Reset values: `arb_gnt` = 0, `obuf_rdy` = 0, `out_vld` = 0, `out_pyld` = 0, `out_src` = 0, pointer = 0, count = 0, FSM = IDLE. Reset mid-operation discards both FIFO entries and any grant with no drain.

## Timing
- From a request to `arb_gnt`: 1 cycle (the request is sampled at edge k, the grant is visible after edge k).
- From the transfer edge to `out_vld`: 1 cycle. The minimum request-to-link latency is 2 cycles.
- `obuf_rdy` rises on the first edge after reset is released.
- Once the FIFO is full, `obuf_rdy` stays low for at least 1 cycle after the first pop.
- Sustained throughput is 1 payload/cycle when `out_rdy` is held high and ≥2 ports are requesting.

## Configuration
- `OBUF_A_RR_EN` defined: round-robin selection as described above.
- `OBUF_A_RR_EN` undefined:
  - Fixed priority, lowest index wins (N > W > S > E > B).
  - The pointer register is removed.
  - All other behaviour is identical.

## Test plan
- Reset and single request: hold `rst`=1 for 3 cycles, then release. Raise `req_i`=5'b00100 with the port-2 payload = 23'h1A5A5A. Expect `arb_gnt`=5'b00100 one cycle later, a transfer with `obuf_rdy`=1, then `out_vld`=1, `out_pyld`=23'h1A5A5A, `out_src`=2.
- Round-robin fairness (with `OBUF_A_RR_EN`): keep `req_i`=5'b11111 by re-raising each request after its transfer, with `out_rdy`=1. The grant order must be 0,1,2,3,4,0 over 6 consecutive cycles.
- Fixed priority (without `OBUF_A_RR_EN`): with `req_i`=5'b10010 the grant is 5'b00010. After port 1 is served, the grant moves to port 4.
- Backpressure: with `out_rdy`=0 and 3 requesters, two transfers occur. `obuf_rdy` then drops to 0 and the third grant is held. Raising `out_rdy` for 1 cycle gives a pop, `obuf_rdy`=1 on the following cycle, and then the third transfer completes.
- Request withdrawal: grant port 3, then drop `req_i[3]` with `obuf_rdy`=1 and no transfer. Expect `arb_gnt`=0 on the next cycle and the pointer unchanged.
- Mid-operation reset: with the FIFO full and a grant held, assert `rst` for 1 cycle. Expect every output at its reset value on the next cycle and no spurious `out_vld`.

Source files
------------

// File: rtl/obuf_a_arb_if.sv
// obuf_a_arb_if
// Bundles the arbiter's request/grant side and its outgoing link into one
// interface.
//
// Request side:
//   req_i    : per-input-port request bits for this output direction.
//   pyld_i   : packed payloads. Port i occupies [i*PYLD_W +: PYLD_W].
//   arb_gnt  : registered grant, one-hot or zero.
//   obuf_rdy : registered; the buffer can take a push this cycle.
//
// Link side:
//   out_vld, out_pyld, out_src : head entry of the buffer.
//   out_rdy                    : downstream accept.
//
// Modports:
//   master : the arbiter.
//   slave  : the environment, i.e. the input controllers plus the link.
interface obuf_a_arb_if #(
    parameter int PYLD_W = 23,
    parameter int NSRC   = 5
);
    logic [NSRC-1:0]        req_i;
    logic [NSRC*PYLD_W-1:0] pyld_i;
    logic [NSRC-1:0]        arb_gnt;
    logic                   obuf_rdy;
    logic                   out_vld;
    logic [PYLD_W-1:0]      out_pyld;
    logic [2:0]             out_src;
    logic                   out_rdy;

    modport master (
        input  req_i, pyld_i, out_rdy,
        output arb_gnt, obuf_rdy, out_vld, out_pyld, out_src
    );

    modport slave (
        output req_i, pyld_i, out_rdy,
        input  arb_gnt, obuf_rdy, out_vld, out_pyld, out_src
    );
endinterface

// File: rtl/obuf_a_arb.sv
// obuf_a_arb
// Output-port arbiter and two-entry output buffer for one mesh direction.
// The block picks one of the five requesting input ports, grants it, and
// captures the granted payload together with its source index into a
// 2-deep FIFO. That FIFO feeds the outgoing link.
//
// Build option: OBUF_A_RR_EN.
//   Defined   : round-robin winner search starting at a 3-bit pointer.
//   Undefined : fixed priority, lowest index wins. No pointer register.
//
// Ports:
//   clk, rst  : clock; synchronous active-high reset.
//   bus       : obuf_a_arb_if.master (req_i, pyld_i, arb_gnt, obuf_rdy,
//               out_vld, out_pyld, out_src, out_rdy).
//   dbg_state : arbiter FSM state (0 = IDLE, 1 = GRANT).
//   dbg_ptr   : round-robin pointer (constant 0 in fixed-priority builds).
//
// Handshakes:
//   Push : a push happens when |(arb_gnt & req_i) & obuf_rdy.
//          arb_gnt and obuf_rdy are both registered.
//   Pop  : a pop happens when out_vld & out_rdy.
//          out_vld, out_pyld and out_src come only from registers, so there
//          is no combinational path from out_rdy.
module obuf_a_arb #(
    parameter int PYLD_W = 23,
    parameter int NSRC   = 5
) (
    input  logic         clk,
    input  logic         rst,
    obuf_a_arb_if.master bus,
    output logic [0:0]   dbg_state,
    output logic [2:0]   dbg_ptr
);
    localparam int ENT_W = 3 + PYLD_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [NSRC-1:0]   gnt_q, gnt_d;
    logic              rdy_q, rdy_d;
    logic [ENT_W-1:0]  mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [2:0]        ptr_q;
    logic [2:0]        next_start;
    logic              push, pop;
    logic [2:0]        win_idx;
    logic [PYLD_W-1:0] win_pyld;
    logic [NSRC-1:0]   rest_req;

    // Return the first set bit of mask, searching upward from start with
    // wrap-around. The result is one-hot, or zero when mask is empty.
    function automatic logic [NSRC-1:0] pick(input logic [NSRC-1:0] mask,
                                             input logic [2:0]      start);
        logic [NSRC-1:0] r;
        logic [3:0]      s;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            s = {1'b0, start} + 4'(k);
            if (s >= 4'(NSRC)) s = s - 4'(NSRC);
            if (!found && mask[s[2:0]]) begin
                r[s[2:0]] = 1'b1;
                found     = 1'b1;
            end
        end
        return r;
    endfunction

    // Decode the held grant into an index and select the matching payload.
    always_comb begin
        win_idx  = 3'd0;
        win_pyld = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_q[i]) begin
                win_idx  = 3'(i);
                win_pyld = bus.pyld_i[i*PYLD_W +: PYLD_W];
            end
        end
    end

    assign push     = (|(gnt_q & bus.req_i)) & rdy_q;
    assign pop      = (count_q != 2'd0) & bus.out_rdy;
    assign rest_req = bus.req_i & ~gnt_q;

`ifdef OBUF_A_RR_EN
    logic [2:0] ptr_adv;

    assign ptr_adv    = (win_idx == 3'(NSRC - 1)) ? 3'd0 : win_idx + 3'd1;
    // A back-to-back pick must already use the advanced pointer.
    assign next_start = ptr_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 3'd0;
        end else if (push) begin
            ptr_q <= ptr_adv;
        end
    end
`else
    assign ptr_q      = 3'd0;
    assign next_start = 3'd0;
`endif

    // Arbiter FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    gnt_d   = pick(bus.req_i, ptr_q);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (push) begin
                    // The served port drops its request next edge, so the
                    // winner is chosen only among the other ports.
                    gnt_d   = pick(rest_req, next_start);
                    state_d = (|rest_req) ? ST_GRANT : ST_IDLE;
                end else if (!(|(gnt_q & bus.req_i))) begin
                    // The granted port withdrew without a transfer.
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. obuf_rdy is deliberately conservative: it ignores
    // a same-cycle pop, so a full buffer reopens only one cycle later.
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        rdy_d   = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rdy_q    <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {win_idx, win_pyld};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bus.arb_gnt  = gnt_q;
    assign bus.obuf_rdy = rdy_q;
    assign bus.out_vld  = (count_q != 2'd0);
    assign bus.out_src  = mem_q[rd_ptr_q][ENT_W-1 -: 3];
    assign bus.out_pyld = mem_q[rd_ptr_q][PYLD_W-1:0];
    assign dbg_state    = state_q;
    assign dbg_ptr      = ptr_q;
endmodule

// File: tb/tb_obuf_a_arb.sv
// tb_obuf_a_arb
// Bench for obuf_a_arb. A cycle model of the arbiter and FIFO supplies the
// expected grant, ready and valid values. Transferred {src, payload} entries
// go into exp_q and are compared at the head of the link.
module tb_obuf_a_arb;
    localparam int PYLD_W = 23;
    localparam int NSRC   = 5;
    localparam int W      = 3 + PYLD_W;
`ifdef OBUF_A_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [0:0] dbg_state;
    logic [2:0] dbg_ptr;

    obuf_a_arb_if #(.PYLD_W(PYLD_W), .NSRC(NSRC)) bus ();

    obuf_a_arb #(.PYLD_W(PYLD_W), .NSRC(NSRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    int                n_checks = 0;
    int                n_pass   = 0;
    logic [W-1:0]      exp_q[$];
    logic [4:0]        pend;
    logic [PYLD_W-1:0] pyld [NSRC];
    bit                rearm;

    // Model of the DUT registers, following the described behaviour.
    logic [4:0] m_gnt;
    logic [2:0] m_ptr;
    int         m_cnt;
    bit         m_rdy;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [4:0] mpick(input logic [4:0] m,
                                         input logic [2:0] start);
        logic [2:0] j;
        for (int k = 0; k < 5; k++) begin
            j = 3'((int'(start) + k) % 5);
            if (m[j]) return 5'b00001 << j;
        end
        return 5'b00000;
    endfunction

    task automatic model_reset();
        m_gnt = '0;
        m_ptr = '0;
        m_cnt = 0;
        m_rdy = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge. The task drives the inputs, checks the
    // outputs against the model, advances one clock, and returns at the
    // next falling edge.
    task automatic step(input bit ordy);
        bit           push;
        bit           pop;
        logic [2:0]   w;
        logic [4:0]   n_gnt;
        logic [2:0]   n_ptr;
        logic [W-1:0] head;

        bus.req_i   = pend;
        for (int i = 0; i < NSRC; i++) bus.pyld_i[i*PYLD_W +: PYLD_W] = pyld[i];
        bus.out_rdy = ordy;

        check("arb_gnt", 32'(bus.arb_gnt), 32'(m_gnt));
        check("obuf_rdy", 32'(bus.obuf_rdy), 32'(m_rdy));
        check("out_vld", 32'(bus.out_vld), 32'(m_cnt != 0));
        check("fsm_state", 32'(dbg_state), 32'(m_gnt != 0));
        check("ptr", 32'(dbg_ptr), 32'(m_ptr));

        if (m_cnt != 0) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("out_src", 32'(bus.out_src), 32'(head[W-1 -: 3]));
                check("out_pyld", 32'(bus.out_pyld), 32'(head[PYLD_W-1:0]));
            end
        end

        pop  = (m_cnt != 0) && ordy;
        push = ((m_gnt & pend) != 0) && m_rdy;
        w    = 3'd0;
        for (int i = 0; i < 5; i++) if (m_gnt[i]) w = 3'(i);

        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (push) exp_q.push_back({w, pyld[w]});

        n_gnt = m_gnt;
        n_ptr = m_ptr;
        if (m_gnt == 5'b0) begin
            if (pend != 5'b0) n_gnt = mpick(pend, RR ? m_ptr : 3'd0);
        end else if (push) begin
            if (RR) n_ptr = (w == 3'd4) ? 3'd0 : w + 3'd1;
            n_gnt = mpick(pend & ~m_gnt, RR ? n_ptr : 3'd0);
        end else if ((m_gnt & pend) == 5'b0) begin
            n_gnt = 5'b0;
        end

        @(posedge clk);
        m_gnt = n_gnt;
        m_ptr = n_ptr;
        m_cnt = m_cnt + int'(push) - int'(pop);
        m_rdy = (m_cnt != 2);
        if (push) begin
            if (rearm) pyld[w] = PYLD_W'($urandom);
            else       pend[w] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(bus.arb_gnt), 32'd0);
        check({tag, "_rdy"}, 32'(bus.obuf_rdy), 32'd0);
        check({tag, "_vld"}, 32'(bus.out_vld), 32'd0);
        check({tag, "_pyld"}, 32'(bus.out_pyld), 32'd0);
        check({tag, "_src"}, 32'(bus.out_src), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        model_reset();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] held;
        logic [2:0] ptr_saved;

        rst         = 1'b1;
        pend        = '0;
        rearm       = 1'b0;
        for (int i = 0; i < NSRC; i++) pyld[i] = '0;
        bus.req_i   = '0;
        bus.pyld_i  = '0;
        bus.out_rdy = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset, then one request.
        apply_reset(3);
        step(1'b1);
        check("rdy_rise", 32'(bus.obuf_rdy), 32'd1);
        pend    = 5'b00100;
        pyld[2] = 23'h1A5A5A;
        step(1'b1);
        check("t1_gnt", 32'(bus.arb_gnt), 32'h04);
        step(1'b1);
        check("t1_vld", 32'(bus.out_vld), 32'd1);
        check("t1_pyld", 32'(bus.out_pyld), 32'h1A5A5A);
        check("t1_src", 32'(bus.out_src), 32'd2);
        run_idle(3);

        // Grant order under continuous requests.
        apply_reset(1);
        for (int i = 0; i < NSRC; i++) pyld[i] = PYLD_W'($urandom);
        if (RR) begin
            rearm = 1'b1;
            pend  = 5'b11111;
            step(1'b1);
            for (int k = 0; k < 6; k++) begin
                check("rr_order", 32'(bus.arb_gnt), 32'(5'b00001 << (k % 5)));
                step(1'b1);
            end
            rearm = 1'b0;
            pend  = '0;
        end else begin
            pend = 5'b10010;
            step(1'b1);
            check("fp_first", 32'(bus.arb_gnt), 32'h02);
            step(1'b1);
            check("fp_second", 32'(bus.arb_gnt), 32'h10);
        end
        run_idle(4);

        // Backpressure with three requesters.
        for (int i = 0; i < NSRC; i++) pyld[i] = PYLD_W'($urandom);
        pend = 5'b01011;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("bp_rdy_low", 32'(bus.obuf_rdy), 32'd0);
        check("bp_full", 32'(bus.out_vld), 32'd1);
        held = bus.arb_gnt;
        check("bp_gnt_set", 32'(held != 5'b0), 32'd1);
        step(1'b0);
        check("bp_gnt_hold", 32'(bus.arb_gnt), 32'(held));
        step(1'b1);
        check("bp_rdy_back", 32'(bus.obuf_rdy), 32'd1);
        step(1'b0);
        check("bp_third_done", 32'(bus.arb_gnt), 32'd0);
        run_idle(4);

        // Request withdrawn while granted.
        pend    = 5'b01000;
        pyld[3] = PYLD_W'($urandom);
        step(1'b1);
        check("wd_gnt", 32'(bus.arb_gnt), 32'h08);
        ptr_saved = dbg_ptr;
        pend      = 5'b00000;
        step(1'b1);
        check("wd_gnt_drop", 32'(bus.arb_gnt), 32'd0);
        check("wd_ptr_kept", 32'(dbg_ptr), 32'(ptr_saved));
        run_idle(2);

        // Reset while the FIFO is full and a grant is held.
        for (int i = 0; i < NSRC; i++) pyld[i] = PYLD_W'($urandom);
        pend = 5'b00111;
        repeat (4) step(1'b0);
        check("mr_pre_full", 32'(bus.obuf_rdy), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mr");
        model_reset();
        pend = '0;
        rst  = 1'b0;
        run_idle(3);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pyld[i] = PYLD_W'($urandom);
                end
            end
            if ($urandom_range(0, 15) == 0) pend[$urandom_range(0, 4)] = 1'b0;
            step($urandom_range(0, 3) != 0);
        end
        pend = '0;
        run_idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
